// File: rtl/c_prbs_checker.sv
// -----------------------------------------------------------------------------
// c_fbmult / c_prbs_checker
//
// c_fbmult: combinational multi-step LFSR next-state function (Galois form).
//    The register is shifted towards higher indices. Bit width-1 is the bit
//    shifted out, and when it is set the feedback vector is XORed in.
//    feedback  [0:width-1]  feedback polynomial taps
//    complete  1            insert the all-zeros state into the sequence
//    data_in   [0:width-1]  current LFSR state
//    data_out  [0:width-1]  state after 'iterations' steps
//
// c_prbs_checker: self-synchronising PRBS stream checker for link/channel BIST.
//    It seeds from the stream and acquires lock after lock_threshold matching
//    words. While locked it flywheels on its own prediction, then counts and
//    flags mismatches. It drops lock after unlock_threshold consecutive misses.
//    clk           clock
//    reset         asynchronous active-low reset
//    active        clock enable; all state holds while low
//    feedback      LFSR polynomial (quasi-static)
//    complete      de Bruijn completion flag (quasi-static)
//    resync        synchronous force to UNLOCKED
//    clear_errors  synchronous clear of error_count
//    valid_in      data_in carries a stream word this cycle
//    data_in       received LFSR state word
//    locked        registered, high in LOCKED
//    error         registered one-cycle pulse per counted mismatch
//    error_count   registered saturating mismatch counter
// -----------------------------------------------------------------------------

module c_fbmult #(
   parameter int width      = 16,
   parameter int iterations = 1
) (
   input  logic [0:width-1] feedback,
   input  logic             complete,
   input  logic [0:width-1] data_in,
   output logic [0:width-1] data_out
);

   // Single Galois step. With complete set, the shifted-out bit is inverted
   // whenever every other bit is zero. This splices 0 in after the state
   // 0...01 and makes 0 lead on to the feedback state.
   function automatic logic [0:width-1] lfsr_step(
      input logic [0:width-1] fb,
      input logic             cmp,
      input logic [0:width-1] st
   );
      logic             out_s;
      logic [0:width-1] nxt_s;
      out_s = st[width-1] ^ (cmp & ~(|st[0:width-2]));
      nxt_s = {1'b0, st[0:width-2]};
      if (out_s) begin
         nxt_s = nxt_s ^ fb;
      end else begin
         nxt_s = nxt_s;
      end
      return nxt_s;
   endfunction

   logic [0:width-1] state_s;

   // Unrolled chain of 'iterations' LFSR steps.
   always_comb begin
      state_s = data_in;
      for (int i = 0; i < iterations; i++) begin
         state_s = lfsr_step(feedback, complete, state_s);
      end
      data_out = state_s;
   end

endmodule

module c_prbs_checker #(
   parameter int width            = 16,
   parameter int iterations       = 1,
   parameter int lock_threshold   = 4,
   parameter int unlock_threshold = 4,
   parameter int cnt_width        = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 active,
   input  logic [0:width-1]     feedback,
   input  logic                 complete,
   input  logic                 resync,
   input  logic                 clear_errors,
   input  logic                 valid_in,
   input  logic [0:width-1]     data_in,
   output logic                 locked,
   output logic                 error,
   output logic [0:cnt_width-1] error_count
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   localparam logic [8:0]           LOCK_THR   = 9'(lock_threshold);
   localparam logic [8:0]           UNLOCK_THR = 9'(unlock_threshold);
   localparam logic [0:cnt_width-1] CNT_ZERO   = cnt_width'(32'd0);
   localparam logic [0:cnt_width-1] CNT_ONE    = cnt_width'(32'd1);

   state_t               state_r;
   logic [0:width-1]     ref_r;
   logic [7:0]           match_cnt_r;
   logic [7:0]           miss_cnt_r;

   logic [0:width-1]     expected_s;
   logic                 match_s;
   logic                 lock_hit_s;
   logic                 unlock_hit_s;
   logic [0:cnt_width-1] cnt_base_s;
   logic [0:cnt_width-1] cnt_inc_s;

   c_fbmult #(
      .width      (width),
      .iterations (iterations)
   ) u_fbmult (
      .feedback (feedback),
      .complete (complete),
      .data_in  (ref_r),
      .data_out (expected_s)
   );

   // Comparison, threshold hits, and the error counter's next value. The
   // clear is applied before the increment so a same-cycle miss reads as 1.
   always_comb begin
      match_s      = (data_in == expected_s);
      lock_hit_s   = (({1'b0, match_cnt_r} + 9'd1) == LOCK_THR);
      unlock_hit_s = (({1'b0, miss_cnt_r} + 9'd1) == UNLOCK_THR);
      if (clear_errors) begin
         cnt_base_s = CNT_ZERO;
      end else begin
         cnt_base_s = error_count;
      end
      if (&cnt_base_s) begin
         cnt_inc_s = cnt_base_s;
      end else begin
         cnt_inc_s = cnt_base_s + CNT_ONE;
      end
   end

   // Lock FSM with registered locked/error/error_count outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= UNLOCKED;
         ref_r       <= {width{1'b0}};
         match_cnt_r <= 8'd0;
         miss_cnt_r  <= 8'd0;
         locked      <= 1'b0;
         error       <= 1'b0;
         error_count <= CNT_ZERO;
      end else if (active) begin
         if (resync) begin
            state_r     <= UNLOCKED;
            match_cnt_r <= 8'd0;
            miss_cnt_r  <= 8'd0;
            locked      <= 1'b0;
            error       <= 1'b0;
            error_count <= cnt_base_s;
         end else begin
            error       <= 1'b0;
            error_count <= cnt_base_s;
            if (valid_in) begin
               case (state_r)
                  UNLOCKED: begin
                     ref_r       <= data_in;
                     match_cnt_r <= 8'd0;
                     state_r     <= ACQUIRE;
                     locked      <= 1'b0;
                  end
                  ACQUIRE: begin
                     // Any mismatch simply reseeds from the received word.
                     ref_r <= data_in;
                     if (match_s) begin
                        if (lock_hit_s) begin
                           state_r     <= LOCKED;
                           locked      <= 1'b1;
                           match_cnt_r <= 8'd0;
                           miss_cnt_r  <= 8'd0;
                        end else begin
                           match_cnt_r <= match_cnt_r + 8'd1;
                        end
                     end else begin
                        match_cnt_r <= 8'd0;
                     end
                  end
                  LOCKED: begin
                     // Flywheel: bad data never reaches the reference.
                     ref_r <= expected_s;
                     if (match_s) begin
                        miss_cnt_r <= 8'd0;
                     end else begin
                        error       <= 1'b1;
                        error_count <= cnt_inc_s;
                        if (unlock_hit_s) begin
                           state_r    <= UNLOCKED;
                           locked     <= 1'b0;
                           miss_cnt_r <= 8'd0;
                        end else begin
                           miss_cnt_r <= miss_cnt_r + 8'd1;
                        end
                     end
                  end
                  default: begin
                     state_r     <= UNLOCKED;
                     locked      <= 1'b0;
                     match_cnt_r <= 8'd0;
                     miss_cnt_r  <= 8'd0;
                  end
               endcase
            end else begin
               state_r <= state_r;
            end
         end
      end else begin
         state_r <= state_r;
      end
   end

endmodule

// File: tb/tb_c_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_c_prbs_checker: directed bench for c_prbs_checker. The checker is set up
// with width=4, feedback=4'b1100 and complete=0. Two instances share all
// inputs: dut has a 16-bit error counter and dut_c has a 2-bit error counter.
// The reference stream is the hand-derived 15-word maximal sequence for this
// polynomial.
// -----------------------------------------------------------------------------

module tb_c_prbs_checker;

   logic        clk;
   logic        reset;
   logic        active;
   logic [0:3]  feedback;
   logic        complete;
   logic        resync;
   logic        clear_errors;
   logic        valid_in;
   logic [0:3]  data_in;
   logic        locked;
   logic        error;
   logic [0:15] error_count;
   logic        locked_c;
   logic        error_c;
   logic [0:1]  error_count_c;

   int vectors = 0;
   int errs    = 0;
   int pos     = 0;

   logic [3:0] seq [0:14] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                              4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

   c_prbs_checker #(.width(4), .iterations(1), .lock_threshold(4),
                    .unlock_threshold(4), .cnt_width(16)) dut (
      .clk (clk), .reset (reset), .active (active), .feedback (feedback),
      .complete (complete), .resync (resync), .clear_errors (clear_errors),
      .valid_in (valid_in), .data_in (data_in), .locked (locked),
      .error (error), .error_count (error_count)
   );

   c_prbs_checker #(.width(4), .iterations(1), .lock_threshold(4),
                    .unlock_threshold(4), .cnt_width(2)) dut_c (
      .clk (clk), .reset (reset), .active (active), .feedback (feedback),
      .complete (complete), .resync (resync), .clear_errors (clear_errors),
      .valid_in (valid_in), .data_in (data_in), .locked (locked_c),
      .error (error_c), .error_count (error_count_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] word_at(input int p);
      return seq[p % 15];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d);
      valid_in = v;
      data_in  = d;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic do_reset();
      valid_in     = 1'b0;
      resync       = 1'b0;
      clear_errors = 1'b0;
      active       = 1'b1;
      reset        = 1'b0;
      tick();
      #2;
      reset = 1'b1;
   endtask

   task automatic lock5(input string tag);
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, word_at(pos));
         pos++;
         chk({tag, "_locked"}, 16'(locked), (k == 5) ? 16'd1 : 16'd0);
         chk({tag, "_err"}, 16'(error), 16'd0);
      end
   endtask

   initial begin
      reset = 1'b0; active = 1'b1; feedback = 4'b1100; complete = 1'b0;
      resync = 1'b0; clear_errors = 1'b0; valid_in = 1'b0; data_in = 4'h0;

      // Reset state
      #12;
      chk("rst_locked", 16'(locked), 16'd0);
      chk("rst_error", 16'(error), 16'd0);
      chk("rst_count", error_count, 16'd0);
      chk("rst_count_c", 16'(error_count_c), 16'd0);
      tick();
      #2 reset = 1'b1;

      // Clean lock over 20 words
      pos = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, word_at(pos));
         pos++;
         chk("clean_locked", 16'(locked), (k >= 5) ? 16'd1 : 16'd0);
         chk("clean_err", 16'(error), 16'd0);
      end
      chk("clean_count", error_count, 16'd0);

      // Single bit error on word 10
      do_reset();
      pos = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, (k == 10) ? (word_at(pos) ^ 4'b1000) : word_at(pos));
         pos++;
         chk("sbe_locked", 16'(locked), (k >= 5) ? 16'd1 : 16'd0);
         chk("sbe_err", 16'(error), (k == 10) ? 16'd1 : 16'd0);
         if (k == 10) chk("sbe_count10", error_count, 16'd1);
      end
      chk("sbe_count", error_count, 16'd1);

      // Loss of lock after 4 bad words, with an error hold under active=0
      do_reset();
      pos = 3;
      lock5("lol_acq");
      for (int b = 1; b <= 4; b++) begin
         drive(1'b1, word_at(pos) ^ 4'b0110);
         pos++;
         chk("lol_err", 16'(error), 16'd1);
         chk("lol_count", error_count, 16'(b));
         chk("lol_count_c", 16'(error_count_c), (b > 3) ? 16'd3 : 16'(b));
         chk("lol_locked", 16'(locked), (b < 4) ? 16'd1 : 16'd0);
         if (b == 1) begin
            active = 1'b0;
            drive(1'b1, 4'h0);
            active = 1'b1;
            chk("lol_hold_err", 16'(error), 16'd1);
            chk("lol_hold_count", error_count, 16'd1);
         end
      end
      lock5("lol_relock");
      chk("lol_final_count", error_count, 16'd4);

      // Gaps and clock gating
      do_reset();
      pos = 7;
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, word_at(pos));
         pos++;
         chk("gap_locked", 16'(locked), (k >= 5) ? 16'd1 : 16'd0);
         chk("gap_err", 16'(error), 16'd0);
         drive(1'b0, 4'hF);
         chk("gap_idle_locked", 16'(locked), (k >= 5) ? 16'd1 : 16'd0);
         chk("gap_idle_err", 16'(error), 16'd0);
         if (k == 3) begin
            active = 1'b0;
            for (int g = 0; g < 3; g++) begin
               drive(1'b1, 4'h0);
               chk("gap_off_locked", 16'(locked), 16'd0);
            end
            active = 1'b1;
         end
      end
      chk("gap_count", error_count, 16'd0);

      // Counter saturation, clear, resync
      do_reset();
      pos = 0;
      lock5("cnt_acq");
      for (int b = 1; b <= 5; b++) begin
         drive(1'b1, word_at(pos) ^ 4'b0110);
         pos++;
         chk("sat_err", 16'(error_c), 16'd1);
         chk("sat_count_c", 16'(error_count_c), (b > 3) ? 16'd3 : 16'(b));
         chk("sat_count", error_count, 16'(b));
         drive(1'b1, word_at(pos));
         pos++;
         chk("sat_good_err", 16'(error_c), 16'd0);
      end
      clear_errors = 1'b1;
      drive(1'b1, word_at(pos) ^ 4'b0110);
      pos++;
      clear_errors = 1'b0;
      chk("clr_err", 16'(error_c), 16'd1);
      chk("clr_count_c", 16'(error_count_c), 16'd1);
      chk("clr_count", error_count, 16'd1);
      chk("clr_locked", 16'(locked_c), 16'd1);
      resync = 1'b1;
      drive(1'b1, word_at(pos) ^ 4'b0110);
      resync = 1'b0;
      chk("rsy_locked", 16'(locked_c), 16'd0);
      chk("rsy_err", 16'(error_c), 16'd0);
      chk("rsy_count_c", 16'(error_count_c), 16'd1);
      resync = 1'b1;
      clear_errors = 1'b1;
      drive(1'b0, 4'h0);
      resync = 1'b0;
      clear_errors = 1'b0;
      chk("rsyclr_count_c", 16'(error_count_c), 16'd0);
      chk("rsyclr_count", error_count, 16'd0);
      // Seed, then an ACQUIRE mismatch that reseeds without counting
      drive(1'b1, word_at(0));
      chk("acq_seed_err", 16'(error), 16'd0);
      drive(1'b1, word_at(5));
      chk("acq_miss_err", 16'(error), 16'd0);
      chk("acq_miss_count", error_count, 16'd0);
      for (int k = 6; k <= 9; k++) begin
         drive(1'b1, word_at(k));
         chk("acq_reseed_locked", 16'(locked), (k == 9) ? 16'd1 : 16'd0);
      end

      // Asynchronous reset mid-operation
      do_reset();
      pos = 2;
      lock5("ar_acq");
      drive(1'b1, word_at(pos) ^ 4'b0110); pos++;
      drive(1'b1, word_at(pos)); pos++;
      drive(1'b1, word_at(pos) ^ 4'b0110); pos++;
      chk("ar_pre_count", error_count, 16'd2);
      chk("ar_pre_err", 16'(error), 16'd1);
      chk("ar_pre_locked", 16'(locked), 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("ar_locked", 16'(locked), 16'd0);
      chk("ar_err", 16'(error), 16'd0);
      chk("ar_count", error_count, 16'd0);
      tick();
      chk("ar_held_locked", 16'(locked), 16'd0);
      #2 reset = 1'b1;
      lock5("ar_relock");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
